brent_kung_adder: RTL and testbench

- Parameterised N-bit two-operand adder with carry-in, built on a Brent-Kung parallel-prefix carry network.
- Result and carry-out are registered.
- Used as the fast adder in datapath blocks where ripple-carry delay is unacceptable.
- Clock: `clk`. Reset: `rst_n`, synchronous, active-low.

---
 rtl/bk_pkg.sv | 23 ++
 rtl/bk_black_cell.sv | 12 +
 rtl/brent_kung_adder.sv | 122 ++++++++++++
 tb/tb_brent_kung_adder.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/bk_pkg.sv
// Shared types and helpers for the Brent-Kung prefix adder.
// gp_t carries one (generate, propagate) pair through the prefix tree.
package bk_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Up-sweep level count for an n-bit tree; the down-sweep uses one fewer.
    function automatic int bk_levels(input int n);
        return $clog2(n);
    endfunction

    // Group operator: hi is the more-significant span, lo the adjacent lower span.
    function automatic gp_t gp_op(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/bk_black_cell.sv
// Combinational black cell: merges two adjacent (G,P) spans into one.
module bk_black_cell
    import bk_pkg::*;
(
    input  gp_t hi,
    input  gp_t lo,
    output gp_t res
);

    assign res = gp_op(hi, lo);

endmodule

// File: rtl/brent_kung_adder.sv
// Registered N-bit adder with carry-in built on an explicit Brent-Kung
// prefix tree. There is no handshake: a, b and cin are sampled on every
// rising edge and the matching sum/cout appear after the configured latency.
// Optional macro BK_INPUT_REG_EN adds an input register stage (latency 2).
module brent_kung_adder
    import bk_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int LV     = bk_levels(N);
    // Stage 0 is the bit-level row; stages 1..LV are the up-sweep,
    // stages LV+1..2*LV-1 the down-sweep.
    localparam int STAGES = 2 * LV;

    if ((N < 2) || (N > 128) || ((N & (N - 1)) != 0)) begin : g_bad_n
        $error("brent_kung_adder: N must be a power of two in 2..128");
    end

    logic [N-1:0] x_a;
    logic [N-1:0] x_b;
    logic         x_cin;

`ifdef BK_INPUT_REG_EN
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic         cin_q;

    // Capture operands ahead of the prefix tree; cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
        end else begin
            a_q   <= a;
            b_q   <= b;
            cin_q <= cin;
        end
    end

    assign x_a   = a_q;
    assign x_b   = b_q;
    assign x_cin = cin_q;
`else
    assign x_a   = a;
    assign x_b   = b;
    assign x_cin = cin;
`endif

    for (genvar s = 0; s < STAGES; s++) begin : stg
        gp_t row [N];

        if (s == 0) begin : g_leaf
            // Bit 0 absorbs cin as a generate at position -1, so every
            // prefix G[i:0] below already equals G[i:-1].
            for (genvar i = 0; i < N; i++) begin : g_bit
                if (i == 0) begin : g_lsb
                    assign row[i] = gp_op('{g: x_a[i] & x_b[i], p: x_a[i] ^ x_b[i]},
                                          '{g: x_cin, p: 1'b0});
                end else begin : g_other
                    assign row[i] = '{g: x_a[i] & x_b[i], p: x_a[i] ^ x_b[i]};
                end
            end
        end else begin : g_level
            localparam bit UP   = (s <= LV);
            localparam int D    = UP ? (s - 1) : (2 * LV - 1 - s);
            localparam int SPAN = 1 << D;

            for (genvar i = 0; i < N; i++) begin : g_node
                // Up-sweep merges spans ending at (i+1) multiples of 2*SPAN;
                // down-sweep fills the half-way nodes from a finished prefix.
                localparam bit COMB = UP ? (((i + 1) % (2 * SPAN)) == 0)
                                         : ((((i + 1) % (2 * SPAN)) == SPAN) && (i >= 2 * SPAN));
                if (COMB) begin : g_black
                    bk_black_cell u_cell (
                        .hi  (stg[s-1].row[i]),
                        .lo  (stg[s-1].row[i-SPAN]),
                        .res (row[i])
                    );
                end else begin : g_pass
                    assign row[i] = stg[s-1].row[i];
                end
            end
        end
    end

    logic [N:0]   c;
    logic [N-1:0] sum_next;
    logic [N-1:0] last_p;
    logic         unused_last_p;

    assign c[0] = x_cin;
    for (genvar i = 0; i < N; i++) begin : g_carry
        assign c[i+1]      = stg[STAGES-1].row[i].g;
        assign last_p[i]   = stg[STAGES-1].row[i].p;
        assign sum_next[i] = x_a[i] ^ x_b[i] ^ c[i];
    end

    // Group propagate of the final row is not needed for the sum.
    assign unused_last_p = ^last_p;

    // Output register; reset wins over the freshly computed result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= sum_next;
            cout <= c[N];
        end
    end

endmodule

// File: tb/tb_brent_kung_adder.sv
// Directed and random checks for brent_kung_adder (N=64) against an
// arithmetic reference model.
module tb_brent_kung_adder;

    localparam int N = 64;
`ifdef BK_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk;
    logic         rst_n;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] sum;
    logic         cout;

    int checks;
    int failures;
    bit cmp_en;

    logic [N:0] exp_q[$];

    brent_kung_adder #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout)
    );

    // Clock and reset defaults.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [N:0] model_add(input logic [N-1:0] x, input logic [N-1:0] y,
                                              input logic ci);
        logic [N:0] r;
        r = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, ci};
        return r;
    endfunction

    task automatic check(input string name, input logic [N:0] act, input logic [N:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual={cout,sum}=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: results flow through LAT stages; reset clears them all.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT; k++) exp_q[k] = '0;
        end else begin
            exp_q.push_back(model_add(a, b, cin));
            void'(exp_q.pop_front());
        end
    end

    // Scoreboard compare on every falling edge once reset has been seen.
    always @(negedge clk) begin
        if (cmp_en) check("model", {cout, sum}, exp_q[0]);
    end

    // Driver: apply one vector, hold it LAT edges, then check a hand value.
    task automatic run_vec(input string name, input logic [N-1:0] va, input logic [N-1:0] vb,
                           input logic vc, input logic [N:0] exp);
        a   = va;
        b   = vb;
        cin = vc;
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        check(name, {cout, sum}, exp);
    endtask

    logic [N-1:0] all1;
    logic [N-1:0] msb;
    logic [N-1:0] ra;
    logic [N-1:0] rb;

    initial begin
        checks   = 0;
        failures = 0;
        cmp_en   = 1'b0;
        for (int k = 0; k < LAT; k++) exp_q.push_back('0);
        all1 = '1;
        msb  = '0;
        msb[N-1] = 1'b1;

        // Reset held with live inputs: outputs stay zero.
        rst_n = 1'b0;
        a     = 64'd255;
        b     = 64'd255;
        cin   = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            cmp_en = 1'b1;
            check("reset_hold", {cout, sum}, 65'd0);
        end
        rst_n = 1'b1;
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        check("reset_release", {cout, sum}, 65'd511);

        // Small directed values.
        run_vec("zero",      64'd0,   64'd0,   1'b0, 65'd0);
        run_vec("a255",      64'd255, 64'd0,   1'b0, 65'd255);
        run_vec("b255_cin",  64'd0,   64'd255, 1'b1, 65'd256);
        run_vec("both255",   64'd255, 64'd255, 1'b0, 65'd510);
        run_vec("both255_c", 64'd255, 64'd255, 1'b1, 65'd511);

        // Full-length carry propagation and MSB carry.
        run_vec("ones_p1",   all1, 64'd0, 1'b1, {1'b1, 64'd0});
        run_vec("ones_ones", all1, all1,  1'b1, {1'b1, all1});
        run_vec("msb_msb",   msb,  msb,   1'b0, {1'b1, 64'd0});
        run_vec("alt_bits",  64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1,
                {1'b1, 64'd0});

        // Back-to-back random sweep; the scoreboard checks every cycle.
        for (int k = 0; k < 100; k++) begin
            a   = 64'(unsigned'($urandom_range(1000000000, 0)));
            b   = 64'(unsigned'($urandom_range(1000000000, 0)));
            cin = 1'($urandom_range(1, 0));
            @(negedge clk);
        end
        for (int k = 0; k < 100; k++) begin
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            cin = 1'($urandom_range(1, 0));
            @(negedge clk);
        end

        // Reset between two random operations.
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        a   = ra;
        b   = rb;
        cin = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_reset", {cout, sum}, 65'd0);
        rst_n = 1'b1;
        a   = 64'd1000;
        b   = 64'd234;
        cin = 1'b0;
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        check("after_reset", {cout, sum}, 65'd1234);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
